// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: {A,B} state encodings,
// the step classification and the Gray-sequence transition decoder.
package quad_pkg;

  localparam logic [1:0] ST00 = 2'b00;
  localparam logic [1:0] ST10 = 2'b10;
  localparam logic [1:0] ST11 = 2'b11;
  localparam logic [1:0] ST01 = 2'b01;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } step_kind_t;

  // Up order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B); any other
  // single-bit change is the reverse direction.
  function automatic step_kind_t quad_step(input logic [1:0] old_ab,
                                           input logic [1:0] new_ab);
    logic [1:0] up_next;
    case (old_ab)
      ST00:    up_next = ST10;
      ST10:    up_next = ST11;
      ST11:    up_next = ST01;
      default: up_next = ST00;
    endcase
    if (new_ab == old_ab)              return NONE;
    if (new_ab == up_next)             return UP;
    if ((new_ab ^ old_ab) == 2'b11)    return ILLEGAL;
    return DOWN;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchroniser for the A/B pair followed by a stability filter that
// accepts a new level only after FILT consecutive identical samples.
module quad_sync_filter
  import quad_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       a_in,
  input  logic       b_in,
  output logic [1:0] ab_f,
  output logic       ab_chg
);

  localparam logic [3:0] FILT_C = 4'(FILT);

  logic [1:0] s1_p0;
  logic [1:0] s2_p1;
  logic [1:0] pend;
  logic [3:0] run_cnt;
  logic [3:0] run_nxt;

  // A run only continues while s2 repeats the same pending level.
  always_comb begin
    run_nxt = 4'd1;
    if (run_cnt != 4'd0 && s2_p1 == pend)
      run_nxt = run_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      // Load from the live pins so releasing clr mid-rotation is silent.
      s1_p0   <= {a_in, b_in};
      s2_p1   <= {a_in, b_in};
      ab_f    <= {a_in, b_in};
      pend    <= {a_in, b_in};
      run_cnt <= 4'd0;
      ab_chg  <= 1'b0;
    end else begin
      // stage p0 -> p1: synchroniser, no logic on the first flop
      s1_p0  <= {a_in, b_in};
      s2_p1  <= s1_p0;
      // stage p1 -> filtered state
      ab_chg <= 1'b0;
      pend   <= s2_p1;
      if (s2_p1 == ab_f) begin
        run_cnt <= 4'd0;
      end else if (run_nxt >= FILT_C) begin
        ab_f    <= s2_p1;
        ab_chg  <= 1'b1;
        run_cnt <= 4'd0;
      end else begin
        run_cnt <= run_nxt;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B pair decoded into up/down steps driving a
// modulo-(n+1) position counter, with illegal-transition error reporting.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             a_in,
  input  logic             b_in,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             err_sticky
);

  logic [1:0] ab_f;
  logic [1:0] ab_prev;
  logic       ab_chg;
  step_kind_t kind;

  function automatic logic [WIDTH-1:0] wrap_up(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] lim);
    return (c >= lim) ? '0 : c + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_down(input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] lim);
    return (c == '0) ? lim : c - WIDTH'(1);
  endfunction

  quad_sync_filter #(
    .FILT (FILT)
  ) u_filt (
    .clk    (clk),
    .clr    (clr),
    .a_in   (a_in),
    .b_in   (b_in),
    .ab_f   (ab_f),
    .ab_chg (ab_chg)
  );

  // ab_prev trails ab_f by one cycle, so on the ab_chg strobe it holds the
  // level that was just replaced.
  always_ff @(posedge clk) begin
    ab_prev <= ab_f;
  end

  always_comb begin
    kind = NONE;
    if (ab_chg)
      kind = quad_step(ab_prev, ab_f);
  end

  // stage: decoded step -> registered position and event outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      count      <= '0;
      dir        <= 1'b1;
      step       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      case (kind)
        UP: begin
          count <= wrap_up(count, n);
          dir   <= 1'b1;
          step  <= 1'b1;
        end
        DOWN: begin
          count <= wrap_down(count, n);
          dir   <= 1'b0;
          step  <= 1'b1;
        end
        ILLEGAL: begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=4, FILT=2): reset, wrap in both
// directions, glitch rejection, illegal transitions and reset behaviour.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       clr;
  logic       a_in;
  logic       b_in;
  logic [3:0] n;
  logic [3:0] count;
  logic       dir;
  logic       step;
  logic       err;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int err_cnt = 0;

  quad_decoder #(.WIDTH(4), .FILT(2)) dut (
    .clk        (clk),
    .clr        (clr),
    .a_in       (a_in),
    .b_in       (b_in),
    .n          (n),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_ab(input logic [1:0] ab);
    a_in = ab[1];
    b_in = ab[0];
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    int s0;
    set_ab(2'b00);
    n = 4'd10;
    do_clr();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", dir); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    checks++; if (step !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses: step=%b err=%b want 0 0", step, err); end
    s0 = step_cnt;
    cyc(20);
    checks++; if (step_cnt != s0) begin errors++; $display("FAIL reset_idle_steps: got %0d want 0", step_cnt - s0); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_idle_count: got %0d want 0", count); end
  endtask

  task automatic test_up_wrap();
    logic [1:0] up_seq [4];
    logic [3:0] exp_cnt;
    int s0;
    up_seq[0] = 2'b10; up_seq[1] = 2'b11; up_seq[2] = 2'b01; up_seq[3] = 2'b00;
    n = 4'd10;
    exp_cnt = 4'd0;
    s0 = step_cnt;
    for (int i = 0; i < 12; i++) begin
      set_ab(up_seq[i % 4]);
      exp_cnt = (exp_cnt >= 4'd10) ? 4'd0 : exp_cnt + 4'd1;
      cyc(4);
      checks++; if (step !== 1'b0) begin errors++; $display("FAIL up_early_%0d: step=%b want 0", i, step); end
      cyc(1);
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL up_step_%0d: step=%b want 1", i, step); end
      checks++; if (count !== exp_cnt || dir !== 1'b1) begin errors++; $display("FAIL up_count_%0d: count=%0d dir=%b want %0d 1", i, count, dir, exp_cnt); end
      cyc(3);
    end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL up_final: got %0d want 1", count); end
    checks++; if (step_cnt - s0 != 12) begin errors++; $display("FAIL up_steps: got %0d want 12", step_cnt - s0); end
  endtask

  task automatic test_down_wrap();
    logic [1:0] dn_seq [4];
    logic [3:0] exp_vals [4];
    dn_seq[0] = 2'b01; dn_seq[1] = 2'b11; dn_seq[2] = 2'b10; dn_seq[3] = 2'b00;
    exp_vals[0] = 4'd15; exp_vals[1] = 4'd14; exp_vals[2] = 4'd13; exp_vals[3] = 4'd12;
    set_ab(2'b00);
    n = 4'd15;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      set_ab(dn_seq[i]);
      cyc(8);
      checks++; if (count !== exp_vals[i] || dir !== 1'b0) begin errors++; $display("FAIL down_%0d: count=%0d dir=%b want %0d 0", i, count, dir, exp_vals[i]); end
    end
  endtask

  task automatic test_glitch();
    int s0;
    s0 = step_cnt;
    set_ab(2'b10);
    cyc(1);
    set_ab(2'b00);
    cyc(10);
    checks++; if (count !== 4'd12 || step_cnt != s0) begin errors++; $display("FAIL glitch_1cyc: count=%0d steps=%0d want 12 0", count, step_cnt - s0); end
    set_ab(2'b10);
    cyc(2);
    set_ab(2'b00);
    cyc(3);
    checks++; if (count !== 4'd13 || dir !== 1'b1) begin errors++; $display("FAIL glitch_2cyc_up: count=%0d dir=%b want 13 1", count, dir); end
    cyc(2);
    checks++; if (count !== 4'd12 || dir !== 1'b0) begin errors++; $display("FAIL glitch_2cyc_down: count=%0d dir=%b want 12 0", count, dir); end
    cyc(6);
    checks++; if (step_cnt - s0 != 2) begin errors++; $display("FAIL glitch_steps: got %0d want 2", step_cnt - s0); end
  endtask

  task automatic test_illegal();
    int e0;
    e0 = err_cnt;
    set_ab(2'b11);
    cyc(4);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_early: err=%b want 0", err); end
    cyc(1);
    checks++; if (err !== 1'b1 || step !== 1'b0) begin errors++; $display("FAIL illegal_pulse: err=%b step=%b want 1 0", err, step); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", err_sticky); end
    checks++; if (count !== 4'd12 || dir !== 1'b0) begin errors++; $display("FAIL illegal_hold: count=%0d dir=%b want 12 0", count, dir); end
    cyc(1);
    checks++; if (err !== 1'b0 || err_cnt - e0 != 1) begin errors++; $display("FAIL illegal_once: err=%b pulses=%0d want 0 1", err, err_cnt - e0); end
    set_ab(2'b01);
    cyc(8);
    checks++; if (count !== 4'd13 || dir !== 1'b1) begin errors++; $display("FAIL illegal_next_up: count=%0d dir=%b want 13 1", count, dir); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL illegal_sticky_hold: got %b want 1", err_sticky); end
    set_ab(2'b00);
    do_clr();
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL illegal_sticky_clr: got %b want 0", err_sticky); end
  endtask

  task automatic test_n_lowered();
    logic [1:0] up_seq [4];
    int s0;
    up_seq[0] = 2'b10; up_seq[1] = 2'b11; up_seq[2] = 2'b01; up_seq[3] = 2'b00;
    n = 4'd10;
    for (int i = 0; i < 9; i++) begin
      set_ab(up_seq[i % 4]);
      cyc(8);
    end
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL nlow_pre: got %0d want 9", count); end
    n = 4'd5;
    cyc(4);
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL nlow_nomove: got %0d want 9", count); end
    set_ab(2'b11);
    cyc(8);
    checks++; if (count !== 4'd0 || dir !== 1'b1) begin errors++; $display("FAIL nlow_wrap: count=%0d dir=%b want 0 1", count, dir); end
    set_ab(2'b01);
    cyc(8);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL nlow_after: got %0d want 1", count); end
  endtask

  task automatic test_clr_mid_filter();
    int s0;
    s0 = step_cnt;
    set_ab(2'b00);
    cyc(2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(10);
    checks++; if (step_cnt != s0) begin errors++; $display("FAIL clrmid_steps: got %0d want 0", step_cnt - s0); end
    checks++; if (count !== 4'd0 || dir !== 1'b1 || err_sticky !== 1'b0) begin errors++; $display("FAIL clrmid_state: count=%0d dir=%b sticky=%b want 0 1 0", count, dir, err_sticky); end
  endtask

  task automatic test_n_zero();
    int s0;
    s0 = step_cnt;
    n = 4'd0;
    set_ab(2'b10);
    cyc(8);
    checks++; if (count !== 4'd0 || dir !== 1'b1) begin errors++; $display("FAIL nzero_up: count=%0d dir=%b want 0 1", count, dir); end
    set_ab(2'b00);
    cyc(8);
    checks++; if (count !== 4'd0 || dir !== 1'b0) begin errors++; $display("FAIL nzero_down: count=%0d dir=%b want 0 0", count, dir); end
    checks++; if (step_cnt - s0 != 2) begin errors++; $display("FAIL nzero_steps: got %0d want 2", step_cnt - s0); end
  endtask

  initial begin
    clr  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    n    = 4'd0;
    cyc(2);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_glitch();
    test_illegal();
    test_n_lowered();
    test_clr_mid_filter();
    test_n_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
